data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Multi-cycle data memory / load-store unit for the MEM stage of the 32-bit RISC-V core.
//  Consumes alu_result as the byte address and rs2 as store data, performs LB/LH/LW/LBU/LHU/SB/SH/SW.
//  Feeds mem_data to the writeback select mux. A busy/done handshake lets the pipeline stall on it.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; word index = addr[log2(DEPTH_WORDS)+1:2], upper bits ignored
//  LATENCY      2    cycles from request acceptance to access edge; legal range >= 1
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high; priority over all other inputs
//  mem_read      in   1   load request
//  mem_write     in   1   store request; wins if asserted together with mem_read
//  funct3        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
//  addr          in   32  byte address (alu_result)
//  write_data    in   32  store data (rs2); low byte/half used for SB/SH
//  mem_data      out  32  load result, registered; holds until the next successful load
//  busy          out  1   state != IDLE
//  done          out  1   one-cycle pulse, state == DONE
//  access_fault  out  1   valid only while done=1: misaligned access or illegal funct3
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, mem_data=0, busy=0, done=0, access_fault=0. Array contents are not reset.
//  FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: on an edge with mem_read|mem_write=1, latch op, funct3, addr and write_data.
//         Set cnt=LATENCY-1 and go to WAIT.
//   WAIT: if cnt==0, perform the access at this edge and go to DONE; else cnt--.
//   DONE: lasts 1 cycle, then IDLE.
//  Timing: accept at edge E0; access at edge E_LATENCY; done=1 in the cycle after E_LATENCY.
//   Back-to-back throughput is one access per LATENCY+2 cycles (IDLE cycle included).
//  Requests presented in WAIT or DONE are ignored, not queued; upstream holds them until it sees IDLE.
//  Little-endian. Byte lane = addr[1:0]. Half lane = addr[1].
//   LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW returns the full word.
//   SB/SH write only the selected byte/half lanes; the other lanes are preserved.
//  Fault cases: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; funct3 011/110/111; store funct3 1xx.
//   All fault cases follow normal timing.
//   On a fault: no array write, mem_data unchanged, access_fault=1 together with done.
//  access_fault=0 whenever done=0.
//  Out-of-range addresses alias modulo DEPTH_WORDS*4 (wrap-around, no fault).
//  Reset mid-operation (WAIT or DONE): abort, discard any pending store, state=IDLE at the next edge.
//  Reset in the same cycle as a new request: the request is dropped.
//  mem_data updates only on a successful load access edge; stores never change it.
// TESTING (DEPTH_WORDS=256, LATENCY=2 unless noted)
//  1 SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> mem_data=0xDEADBEEF.
//    done pulses 3 cycles after the acceptance edge; busy=1 for exactly 3 cycles.
//  2 After test 1: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
//  3 SB 0x11 data=0x12345655, then LW 0x10 -> 0xDEAD55EF (only byte lane 1 changed).
//  4 LW 0x12 -> done=1 with access_fault=1, mem_data keeps the previous value.
//    SH 0x11 data=0xFFFF then LW 0x10 -> still 0xDEAD55EF.
//  5 Issue LW 0x10 while busy from SW 0x20=0x1 -> LW ignored, only one done pulse.
//    Then SW 0x20=0x77 with reset asserted during WAIT -> busy=0 next cycle, LW 0x20 returns 0x00000001.
//  6 Wrap-around: SW 0x400 data=0xA5A5A5A5, then LW 0x0 -> 0xA5A5A5A5.
//    Rerun test 1 with LATENCY=1 -> done 2 cycles after acceptance.

Source files
------------

// File: rtl/data_memory.sv
// Multi-cycle load/store unit for the MEM stage: LB/LH/LW/LBU/LHU/SB/SH/SW on a word array.
// Latency: request accepted in IDLE, access LATENCY edges later, done pulses for one cycle after.
// Backpressure: busy while not IDLE; requests seen outside IDLE are ignored, not queued.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        access_fault
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic           op_wr;
  logic [2:0]     op_f3;
  logic [31:0]    op_addr;
  logic [31:0]    op_wdata;
  logic           fault_q;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept;
  logic           access;
  logic [AW-1:0]  idx;
  logic [31:0]    rd_word;
  logic [31:0]    rd_shift;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    load_val;
  logic [31:0]    store_word;
  logic           misalign;
  logic           bad_f3;
  logic           fault;

  assign accept  = (state == IDLE) && (mem_read || mem_write);
  assign access  = (state == WAIT) && (cnt == '0);
  // Upper address bits are dropped so out-of-range addresses wrap around.
  assign idx     = op_addr[AW+1:2];
  assign rd_word = mem[idx];

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign access_fault = done && fault_q;

  // Fault detection on the latched request: misalignment or unsupported funct3.
  always_comb begin
    misalign = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
               ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    if (op_wr) begin
      bad_f3 = op_f3[2] || (op_f3[1:0] == 2'b11);
    end else begin
      bad_f3 = (op_f3 == 3'b011) || (op_f3[2:1] == 2'b11);
    end
    fault = misalign || bad_f3;
  end

  // Load lane extraction with sign or zero extension (little-endian).
  always_comb begin
    rd_shift = rd_word >> {op_addr[1:0], 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Store merge: only the addressed byte/half lanes are replaced.
  always_comb begin
    store_word = rd_word;
    case (op_f3[1:0])
      2'b00: store_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      2'b01: begin
        if (op_addr[1]) store_word[31:16] = op_wdata[15:0];
        else            store_word[15:0]  = op_wdata[15:0];
      end
      default: store_word = op_wdata;
    endcase
  end

  // Next-state logic for the IDLE -> WAIT -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (access) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request capture on acceptance and latency countdown while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_wr    <= 1'b0;
      op_f3    <= 3'b000;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (accept) begin
      cnt      <= CW'(LATENCY - 1);
      op_wr    <= mem_write;
      op_f3    <= funct3;
      op_addr  <= addr;
      op_wdata <= write_data;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Load result and fault flag update on the access edge; stores never touch mem_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data <= '0;
      fault_q  <= 1'b0;
    end else if (access) begin
      fault_q <= fault;
      if (!op_wr && !fault) mem_data <= load_val;
    end
  end

  // Array write; contents are not reset and a reset cancels a pending store.
  always_ff @(posedge clk) begin
    if (!reset && access && op_wr && !fault) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: LATENCY=2 instance for function/timing, LATENCY=1 for timing.
// Expected values are hand-computed constants.
// Inputs are driven 1ns after the rising edge; outputs are sampled there too.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr0, mw0, mr1, mw1;
  logic [2:0]  f30, f31;
  logic [31:0] a0, a1, wd0, wd1;
  logic [31:0] md0, md1;
  logic        busy0, busy1, done0, done1, flt0, flt1;

  int n_chk  = 0;
  int n_pass = 0;
  int bad_flt = 0;

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(mr0), .mem_write(mw0), .funct3(f30),
    .addr(a0), .write_data(wd0), .mem_data(md0), .busy(busy0), .done(done0),
    .access_fault(flt0)
  );

  data_memory #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(mr1), .mem_write(mw1), .funct3(f31),
    .addr(a1), .write_data(wd1), .mem_data(md1), .busy(busy1), .done(done1),
    .access_fault(flt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to the selected DUT (assumed idle) and wait for its done pulse.
  // lat = cycle index of done after the acceptance edge, nb = busy cycles seen.
  task automatic op(input bit sel, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    output int lat, output logic flt, output int nb);
    logic got;
    got = 1'b0;
    lat = 0;
    flt = 1'b0;
    nb  = 0;
    if (sel) begin mw1 = wr; mr1 = !wr; f31 = f3; a1 = a; wd1 = wd; end
    else     begin mw0 = wr; mr0 = !wr; f30 = f3; a0 = a; wd0 = wd; end
    step();
    mr0 = 1'b0; mw0 = 1'b0; mr1 = 1'b0; mw1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (sel ? busy1 : busy0) nb++;
      if (!(sel ? done1 : done0) && (sel ? flt1 : flt0)) bad_flt++;
      if (sel ? done1 : done0) begin
        lat = i;
        flt = sel ? flt1 : flt0;
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    step();
    if (sel ? busy1 : busy0) nb++;
  endtask

  initial begin
    int   lat, nb, pulses;
    logic flt;

    reset = 1'b1;
    mr0 = 0; mw0 = 0; f30 = 0; a0 = 0; wd0 = 0;
    mr1 = 0; mw1 = 0; f31 = 0; a1 = 0; wd1 = 0;
    step(); step();
    reset = 1'b0;
    chk("rst_mem_data", md0, 32'h0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_fault", {31'd0, flt0}, 32'd0);
    chk("rst_busy_l1", {31'd0, busy1}, 32'd0);

    // Test 1: SW then LW, with timing.
    op(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, flt, nb);
    chk("sw_lat", lat, 3);
    chk("sw_busy_cycles", nb, 3);
    chk("sw_fault", {31'd0, flt}, 32'd0);
    chk("sw_no_md_change", md0, 32'h0);
    op(0, 1'b0, 3'b010, 32'h10, 32'h0, lat, flt, nb);
    chk("lw_lat", lat, 3);
    chk("lw_data", md0, 32'hDEADBEEF);

    // Test 2: sub-word loads.
    op(0, 1'b0, 3'b000, 32'h13, 32'h0, lat, flt, nb);
    chk("lb_13", md0, 32'hFFFFFFDE);
    op(0, 1'b0, 3'b100, 32'h13, 32'h0, lat, flt, nb);
    chk("lbu_13", md0, 32'h000000DE);
    op(0, 1'b0, 3'b001, 32'h12, 32'h0, lat, flt, nb);
    chk("lh_12", md0, 32'hFFFFDEAD);
    op(0, 1'b0, 3'b101, 32'h10, 32'h0, lat, flt, nb);
    chk("lhu_10", md0, 32'h0000BEEF);

    // Test 3: SB touches only lane 1.
    op(0, 1'b1, 3'b000, 32'h11, 32'h12345655, lat, flt, nb);
    op(0, 1'b0, 3'b010, 32'h10, 32'h0, lat, flt, nb);
    chk("sb_merge", md0, 32'hDEAD55EF);

    // Test 4: misaligned and illegal accesses.
    op(0, 1'b0, 3'b010, 32'h12, 32'h0, lat, flt, nb);
    chk("lw_mis_fault", {31'd0, flt}, 32'd1);
    chk("lw_mis_lat", lat, 3);
    chk("lw_mis_md_hold", md0, 32'hDEAD55EF);
    op(0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, lat, flt, nb);
    chk("sh_mis_fault", {31'd0, flt}, 32'd1);
    op(0, 1'b1, 3'b100, 32'h10, 32'h00000000, lat, flt, nb);
    chk("st_f3_fault", {31'd0, flt}, 32'd1);
    op(0, 1'b0, 3'b011, 32'h10, 32'h0, lat, flt, nb);
    chk("ld_f3_fault", {31'd0, flt}, 32'd1);
    op(0, 1'b0, 3'b010, 32'h10, 32'h0, lat, flt, nb);
    chk("no_write_on_fault", md0, 32'hDEAD55EF);
    chk("lw_ok_nofault", {31'd0, flt}, 32'd0);

    // Test 5a: LW presented while busy is ignored.
    mw0 = 1'b1; f30 = 3'b010; a0 = 32'h20; wd0 = 32'h1;
    step();
    mw0 = 1'b0; mr0 = 1'b1; a0 = 32'h10; wd0 = 32'h0;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      if (done0) pulses++;
      step();
    end
    mr0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done0) pulses++;
      step();
    end
    chk("ignored_req_pulses", pulses, 1);
    chk("ignored_req_md", md0, 32'hDEAD55EF);

    // Test 5b: reset during WAIT cancels the store.
    mw0 = 1'b1; f30 = 3'b010; a0 = 32'h20; wd0 = 32'h77;
    step();
    mw0 = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_wait_busy", {31'd0, busy0}, 32'd0);
    chk("rst_wait_md", md0, 32'h0);
    op(0, 1'b0, 3'b010, 32'h20, 32'h0, lat, flt, nb);
    chk("store_cancelled", md0, 32'h00000001);

    // Test 6: wrap-around aliasing.
    op(0, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, lat, flt, nb);
    chk("wrap_fault", {31'd0, flt}, 32'd0);
    op(0, 1'b0, 3'b010, 32'h0, 32'h0, lat, flt, nb);
    chk("wrap_alias", md0, 32'hA5A5A5A5);

    // LATENCY=1 instance: test 1 again.
    op(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, flt, nb);
    chk("l1_sw_lat", lat, 2);
    chk("l1_sw_busy_cycles", nb, 2);
    op(1, 1'b0, 3'b010, 32'h10, 32'h0, lat, flt, nb);
    chk("l1_lw_lat", lat, 2);
    chk("l1_lw_data", md1, 32'hDEADBEEF);

    chk("fault_only_with_done", bad_flt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
